// File: rtl/pipeline_sequencer_pkg.sv
// pipeline_sequencer_pkg
// Shared definitions for the pipeline sequencer: opcode constants, the
// instruction-class enum, the per-stage tracking record and the decoded
// sequencing condition.
// The tracking record's dst field is sized by SEQ_REG_W, so the top-level
// REG_W parameter must stay equal to SEQ_REG_W.
package pipeline_sequencer_pkg;

    localparam int SEQ_REG_W = 5;
    localparam int SEQ_OP_W  = 6;

    localparam logic [SEQ_OP_W-1:0] OP_RFMT = 6'd0;
    localparam logic [SEQ_OP_W-1:0] OP_LW   = 6'd1;
    localparam logic [SEQ_OP_W-1:0] OP_SW   = 6'd2;
    localparam logic [SEQ_OP_W-1:0] OP_BEQ  = 6'd3;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_R,
        CLS_LW,
        CLS_SW,
        CLS_BEQ
    } opClass_t;

    typedef struct packed {
        logic                 valid;
        opClass_t             cls;
        logic [SEQ_REG_W-1:0] dst;
    } stage_t;

    // Decoded pipeline condition. This is the sequencer's observable state:
    // one value per cycle, chosen by priority from the hazard terms.
    typedef enum logic [1:0] {
        COND_RUN,
        COND_LOAD_USE,
        COND_BRANCH,
        COND_MEM_WAIT
    } seqCond_t;

    localparam stage_t STAGE_EMPTY = '{valid: 1'b0, cls: CLS_NOP, dst: '0};

    function automatic logic isMemOp(input opClass_t cls);
        return (cls == CLS_LW) || (cls == CLS_SW);
    endfunction

endpackage

// File: rtl/pipeline_sequencer_op_classify.sv
// op_classify
// Combinational opcode decoder for the instruction in ID.
// Ports:
//   opcode   in   OP_W   opcode field
//   rt, rd   in   REG_W  register fields that can be a destination
//   cls      out         instruction class (CLS_NOP for undefined opcodes)
//   readsRs  out  1      instruction reads rs
//   readsRt  out  1      instruction reads rt
//   dst      out  REG_W  destination register, 0 when nothing is written
//   illegal  out  1      opcode is undefined
// A zero dst for non-writing classes is safe: register 0 is never a
// dependency.
module op_classify
    import pipeline_sequencer_pkg::*;
#(
    parameter int REG_W = SEQ_REG_W,
    parameter int OP_W  = SEQ_OP_W
) (
    input  logic [OP_W-1:0]  opcode,
    input  logic [REG_W-1:0] rt,
    input  logic [REG_W-1:0] rd,
    output opClass_t         cls,
    output logic             readsRs,
    output logic             readsRt,
    output logic [REG_W-1:0] dst,
    output logic             illegal
);

    always_comb begin
        cls     = CLS_NOP;
        readsRs = 1'b0;
        readsRt = 1'b0;
        dst     = '0;
        illegal = 1'b0;
        case (opcode)
            OP_RFMT: begin
                cls     = CLS_R;
                readsRs = 1'b1;
                readsRt = 1'b1;
                dst     = rd;
            end
            OP_LW: begin
                cls     = CLS_LW;
                readsRs = 1'b1;
                dst     = rt;
            end
            OP_SW: begin
                cls     = CLS_SW;
                readsRs = 1'b1;
                readsRt = 1'b1;
            end
            OP_BEQ: begin
                cls     = CLS_BEQ;
                readsRs = 1'b1;
                readsRt = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/pipeline_sequencer.sv
// pipeline_sequencer
// Hazard sequencer for a five-stage pipeline. Tracks {valid, class, dst} for
// EX, MEM and WB and produces the PC / pipeline-register enables, bubbles and
// flushes for load-use hazards, taken branches and data-memory wait states.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   id_valid                  an instruction is present in ID
//   id_opcode                 opcode in ID
//   id_rs, id_rt, id_rd       register fields in ID
//   ex_zero                   ALU zero flag of the instruction in EX
//   mem_ready                 data memory completes its access this cycle
//   pc_en, pc_sel_branch      PC load enable, PC source is branch target
//   ifid_en..memwb_en         pipeline register enables
//   ifid_flush, idex_flush    load a NOP into IF/ID, ID/EX
//   illegal_op                valid instruction with an undefined opcode
//   stall_cnt, flush_cnt      saturating performance counters
// Optional feature: define PERF_CNT_EN to add stall_cnt/flush_cnt.
//
// Handshake: there is no valid/ready pairing on the control side. Each enable
// is a same-cycle qualifier: a register loads on the rising edge only when its
// enable is 1, and a flush overrides the loaded value with a NOP. mem_ready is
// the only back-pressure input and is sampled combinationally every cycle.
//
// All outputs are combinational from the inputs and the tracking registers.
module pipeline_sequencer
    import pipeline_sequencer_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int OP_W  = 6,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [OP_W-1:0]  id_opcode,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic [REG_W-1:0] id_rd,
    input  logic             ex_zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             pc_sel_branch,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             illegal_op
`ifdef PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    stage_t   exStage;
    stage_t   memStage;
    stage_t   wbStage;
    stage_t   idEntry;

    opClass_t         idCls;
    logic             idReadsRs;
    logic             idReadsRt;
    logic             idIllegal;
    logic [REG_W-1:0] idDst;

    logic     memWait;
    logic     branchTaken;
    logic     loadUse;
    seqCond_t cond;

    op_classify #(
        .REG_W (REG_W),
        .OP_W  (OP_W)
    ) u_idClassify (
        .opcode  (id_opcode),
        .rt      (id_rt),
        .rd      (id_rd),
        .cls     (idCls),
        .readsRs (idReadsRs),
        .readsRt (idReadsRt),
        .dst     (idDst),
        .illegal (idIllegal)
    );

    // Hazard terms and priority decode. MEM_WAIT outranks everything so that
    // branch and load-use decisions are simply re-evaluated once the memory
    // answers; BRANCH outranks LOAD_USE because the ID instruction is squashed.
    always_comb begin
        memWait     = memStage.valid && isMemOp(memStage.cls) && !mem_ready;
        branchTaken = exStage.valid && (exStage.cls == CLS_BEQ) && ex_zero;
        loadUse     = id_valid && exStage.valid && (exStage.cls == CLS_LW)
                      && (exStage.dst != '0)
                      && ((idReadsRs && (id_rs == exStage.dst))
                          || (idReadsRt && (id_rt == exStage.dst)));

        if (memWait) begin
            cond = COND_MEM_WAIT;
        end else if (branchTaken) begin
            cond = COND_BRANCH;
        end else if (loadUse) begin
            cond = COND_LOAD_USE;
        end else begin
            cond = COND_RUN;
        end
    end

    always_comb begin
        pc_en         = 1'b1;
        pc_sel_branch = 1'b0;
        ifid_en       = 1'b1;
        idex_en       = 1'b1;
        exmem_en      = 1'b1;
        memwb_en      = 1'b1;
        ifid_flush    = 1'b0;
        idex_flush    = 1'b0;
        case (cond)
            COND_MEM_WAIT: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
            end
            COND_BRANCH: begin
                pc_sel_branch = 1'b1;
                ifid_flush    = 1'b1;
                idex_flush    = 1'b1;
            end
            COND_LOAD_USE: begin
                // ID/EX stays enabled so the bubble is actually loaded.
                pc_en      = 1'b0;
                ifid_en    = 1'b0;
                idex_flush = 1'b1;
            end
            default: ;
        endcase
        illegal_op = id_valid && idIllegal;
    end

    always_comb begin
        idEntry       = STAGE_EMPTY;
        idEntry.valid = id_valid;
        idEntry.cls   = idCls;
        idEntry.dst   = idDst;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exStage  <= STAGE_EMPTY;
            memStage <= STAGE_EMPTY;
            wbStage  <= STAGE_EMPTY;
        end else begin
            if (idex_en) begin
                exStage <= idex_flush ? STAGE_EMPTY : idEntry;
            end
            if (exmem_en) begin
                memStage <= exStage;
            end
            if (memwb_en) begin
                wbStage <= memStage;
            end
        end
    end

    // WB is tracked for completeness of the pipeline picture; no hazard
    // currently depends on it.
    logic unusedWb;
    assign unusedWb = ^wbStage;

`ifdef PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (((cond == COND_LOAD_USE) || (cond == COND_MEM_WAIT))
                && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
            if ((cond == COND_BRANCH) && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
        end
    end
`else
    localparam int unusedCntW = CNT_W;
`endif

endmodule

// File: tb/tb_pipeline_sequencer.sv
// tb_pipeline_sequencer
// Directed test-plan scenarios followed by randomized traffic, all checked
// against an instruction-level pipeline model. Define PERF_CNT_EN to also
// check the performance counters.
module tb_pipeline_sequencer;

    localparam int REG_W = 5;
    localparam int OP_W  = 6;
    localparam int CNT_W = 16;

    localparam logic [5:0] OPV_R   = 6'd0;
    localparam logic [5:0] OPV_LW  = 6'd1;
    localparam logic [5:0] OPV_SW  = 6'd2;
    localparam logic [5:0] OPV_BEQ = 6'd3;

    // Control word: {pc_en, pc_sel_branch, ifid_en, idex_en, exmem_en,
    //                memwb_en, ifid_flush, idex_flush, illegal_op}
    localparam logic [8:0] RUN_W  = 9'b1_0_1111_00_0;
    localparam logic [8:0] LU_W   = 9'b0_0_0111_01_0;
    localparam logic [8:0] BR_W   = 9'b1_1_1111_11_0;
    localparam logic [8:0] WAIT_W = 9'b0_0_0000_00_0;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic             id_valid;
    logic [OP_W-1:0]  id_opcode;
    logic [REG_W-1:0] id_rs, id_rt, id_rd;
    logic             ex_zero, mem_ready;
    logic pc_en, pc_sel_branch, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, illegal_op;
`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
`endif

    pipeline_sequencer #(
        .REG_W (REG_W),
        .OP_W  (OP_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_opcode     (id_opcode),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rd         (id_rd),
        .ex_zero       (ex_zero),
        .mem_ready     (mem_ready),
        .pc_en         (pc_en),
        .pc_sel_branch (pc_sel_branch),
        .ifid_en       (ifid_en),
        .idex_en       (idex_en),
        .exmem_en      (exmem_en),
        .memwb_en      (memwb_en),
        .ifid_flush    (ifid_flush),
        .idex_flush    (idex_flush),
        .illegal_op    (illegal_op)
`ifdef PERF_CNT_EN
        ,
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
`endif
    );

    logic [8:0] ctrlNow;
    assign ctrlNow = {pc_en, pc_sel_branch, ifid_en, idex_en, exmem_en,
                      memwb_en, ifid_flush, idex_flush, illegal_op};

    // scoreboard
    int checks   = 0;
    int failures = 0;
    logic [8:0] exp_q[$];

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // reference model: raw instructions occupying EX, MEM, WB
    typedef struct {
        bit         v;
        logic [5:0] op;
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] rd;
    } instr_t;

    instr_t mEx, mMem, mWb;
    int     mStall, mFlush;

    function automatic logic [4:0] dstOf(input instr_t i);
        if (i.op == OPV_R)  return i.rd;
        if (i.op == OPV_LW) return i.rt;
        return 5'd0;
    endfunction

    function automatic bit usesRs(input logic [5:0] op);
        return op <= OPV_BEQ;
    endfunction

    function automatic bit usesRt(input logic [5:0] op);
        return (op == OPV_R) || (op == OPV_SW) || (op == OPV_BEQ);
    endfunction

    task automatic model_reset();
        mEx    = '{default: '0};
        mMem   = '{default: '0};
        mWb    = '{default: '0};
        mStall = 0;
        mFlush = 0;
    endtask

    // driver: one cycle of ID/EX/MEM inputs, checked before the next edge
    task automatic step(input bit v, input logic [5:0] op, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd,
                        input bit exz, input bit mrdy);
        bit         waitC, brC, luC;
        logic [4:0] exDst;
        logic [8:0] expW;
        @(negedge clk);
        id_valid  = v;
        id_opcode = op;
        id_rs     = rs;
        id_rt     = rt;
        id_rd     = rd;
        ex_zero   = exz;
        mem_ready = mrdy;
        #1;
        exDst = dstOf(mEx);
        waitC = mMem.v && ((mMem.op == OPV_LW) || (mMem.op == OPV_SW)) && !mrdy;
        brC   = mEx.v && (mEx.op == OPV_BEQ) && exz;
        luC   = v && mEx.v && (mEx.op == OPV_LW) && (exDst != 5'd0)
                && ((usesRs(op) && rs == exDst) || (usesRt(op) && rt == exDst));
        if (waitC)     expW = WAIT_W;
        else if (brC)  expW = BR_W;
        else if (luC)  expW = LU_W;
        else           expW = RUN_W;
        expW[0] = v && (op > OPV_BEQ);
        exp_q.push_back(expW);
        check_val("ctrl", ctrlNow, exp_q.pop_front());
`ifdef PERF_CNT_EN
        check_val("stall_cnt", stall_cnt, mStall);
        check_val("flush_cnt", flush_cnt, mFlush);
`endif
        if (waitC) begin
            if (mStall < 65535) mStall++;
        end else begin
            if (brC) begin
                if (mFlush < 65535) mFlush++;
            end else if (luC) begin
                if (mStall < 65535) mStall++;
            end
            mWb  = mMem;
            mMem = mEx;
            if (brC || luC) mEx = '{default: '0};
            else            mEx = '{v: v, op: op, rs: rs, rt: rt, rd: rd};
        end
    endtask

    task automatic step_idle();
        step(1'b0, 6'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    endtask

    int baseStall, baseFlush;

    initial begin
        rst       = 1'b1;
        id_valid  = 1'b0;
        id_opcode = '0;
        id_rs     = '0;
        id_rt     = '0;
        id_rd     = '0;
        ex_zero   = 1'b0;
        mem_ready = 1'b1;
        model_reset();
        #1;
        check_val("reset_ctrl", ctrlNow, RUN_W);
`ifdef PERF_CNT_EN
        check_val("reset_stall", stall_cnt, 0);
        check_val("reset_flush", flush_cnt, 0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // independent R instructions
        step(1, OPV_R, 5'd1, 5'd2, 5'd3, 0, 1);
        step(1, OPV_R, 5'd4, 5'd5, 5'd6, 0, 1);
        check_val("indep_r", ctrlNow, RUN_W);

        // load-use: one bubble, then RUN
        step(1, OPV_LW, 5'd1, 5'd5, 5'd0, 0, 1);
        step(1, OPV_R, 5'd5, 5'd2, 5'd7, 0, 1);
        check_val("lu_bubble", ctrlNow, LU_W);
        step(1, OPV_R, 5'd5, 5'd2, 5'd7, 0, 1);
        check_val("lu_clear", ctrlNow, RUN_W);

        // load to r0 is never a dependency
        step(1, OPV_LW, 5'd1, 5'd0, 5'd0, 0, 1);
        step(1, OPV_R, 5'd0, 5'd0, 5'd8, 0, 1);
        check_val("lu_r0", ctrlNow, RUN_W);

        // taken branch
        step(1, OPV_BEQ, 5'd1, 5'd2, 5'd0, 0, 1);
        step(1, OPV_R, 5'd1, 5'd2, 5'd9, 1, 1);
        check_val("br_taken", ctrlNow, BR_W);
        step_idle();
        check_val("br_after", ctrlNow, RUN_W);

        // SW waiting in MEM with a taken BEQ in EX
        step(1, OPV_SW, 5'd1, 5'd2, 5'd0, 0, 1);
        step(1, OPV_BEQ, 5'd3, 5'd3, 5'd0, 0, 1);
`ifdef PERF_CNT_EN
        baseStall = int'(stall_cnt);
        baseFlush = int'(flush_cnt);
`else
        baseStall = 0;
        baseFlush = 0;
`endif
        for (int k = 0; k < 3; k++) begin
            step(1, OPV_R, 5'd1, 5'd1, 5'd1, 1, 0);
            check_val($sformatf("wait_%0d", k), ctrlNow, WAIT_W);
        end
        step(1, OPV_R, 5'd1, 5'd1, 5'd1, 1, 1);
        check_val("wait_then_br", ctrlNow, BR_W);
        step_idle();
`ifdef PERF_CNT_EN
        check_val("wait_stall_delta", int'(stall_cnt) - baseStall, 3);
        check_val("wait_flush_delta", int'(flush_cnt) - baseFlush, 1);
`endif

        // undefined opcode
        step(1, 6'h3F, 5'd1, 5'd2, 5'd3, 0, 1);
        check_val("illegal", ctrlNow, 9'b1_0_1111_00_1);

        // reset during a load-use stall
        step(1, OPV_LW, 5'd2, 5'd7, 5'd0, 0, 1);
        step(1, OPV_R, 5'd7, 5'd1, 5'd4, 0, 1);
        check_val("lu_before_rst", ctrlNow, LU_W);
        rst = 1'b1;
        model_reset();
        #1;
        check_val("rst_mid_stall", ctrlNow, RUN_W);
`ifdef PERF_CNT_EN
        check_val("rst_stall_cnt", stall_cnt, 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // randomized traffic
        for (int n = 0; n < 600; n++) begin
            int         r;
            logic [5:0] op;
            r = $urandom_range(0, 9);
            if (r < 8)       op = 6'(r % 4);
            else if (r == 8) op = 6'h3F;
            else             op = 6'($urandom_range(4, 62));
            step($urandom_range(0, 7) != 0, op,
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_sequencer.md
# pipeline_sequencer

Sequences the five-stage pipeline around the opcode decoder: it tracks the instruction class and destination register in the EX, MEM and WB stages, and generates per-stage register enables, bubbles and flushes. It covers load-use hazards, taken branches and data-memory wait states. It sits beside the decoder in ID, and its outputs drive the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.

## Interface
- REG_W, 5, register-specifier width
- OP_W, 6, opcode width
- CNT_W, 16, performance-counter width (used only with PERF_CNT_EN)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- id_valid  in  1  an instruction is present in ID
- id_opcode  in  OP_W  opcode in ID
- id_rs, id_rt, id_rd  in  REG_W  register fields in ID
- ex_zero  in  1  ALU zero flag for the instruction in EX
- mem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC register load enable
- pc_sel_branch  out  1  PC loads the branch target instead of PC+4
- ifid_en, idex_en, exmem_en, memwb_en  out  1  pipeline register enables
- ifid_flush, idex_flush  out  1  load a NOP into that register
- illegal_op  out  1  id_valid and id_opcode is undefined
- stall_cnt, flush_cnt  out  CNT_W  performance counters (PERF_CNT_EN only)

## Operation
- Opcode classes:
  - 0 = R-format: writes rd; reads rs and rt.
  - 1 = LW: writes rt; reads rs.
  - 2 = SW: reads rs and rt; memory op.
  - 3 = BEQ: reads rs and rt.
  - Any other opcode is treated as NOP (no reads, no writes) and asserts illegal_op. The illegal instruction still advances.
- Internal tracking per stage for EX, MEM and WB: valid, class and dst. The tracking advances with the pipeline enables. A bubble or flush loads valid=0.
- A write to register 0 is never a dependency.
- Conditions, listed highest priority first:
  1. **MEM_WAIT**: MEM holds a valid LW or SW and mem_ready=0.
     - All enables are 0 and no flushes are asserted; the whole pipeline freezes.
     - Branch and load-use decisions are deferred until the wait ends.
  2. **BRANCH**: EX holds a valid BEQ and ex_zero=1.
     - pc_en=1, pc_sel_branch=1, ifid_flush=1, idex_flush=1.
     - All other enables are 1.
  3. **LOAD_USE**: EX holds a valid LW with dst≠0, and dst equals a source register that the ID instruction reads.
     - pc_en=0, ifid_en=0, idex_flush=1.
     - exmem_en=1, memwb_en=1.
  4. **RUN**: every enable is 1, every flush is 0, pc_sel_branch=0.
- id_valid=0 never causes LOAD_USE.
- A BRANCH and a LOAD_USE condition in the same cycle: BRANCH wins, because the ID instruction is flushed anyway.

## Timing
- All control outputs are combinational from the current inputs and the tracking registers. There are no registered outputs and no added latency.
- The tracking registers update on the clk rising edge.
- Load-use costs exactly 1 bubble cycle; in the following cycle the LW has moved to MEM and the condition clears.
- A taken branch costs 2 squashed instructions.
- MEM_WAIT lasts as long as mem_ready=0, then RUN resumes. The frozen state must be intact when it resumes.
- Reset:
  - All tracking valid bits clear immediately, which gives an empty pipeline. Outputs then decode to RUN with no flush.
  - Counters reset to 0.
  - Reset mid-stall or mid-wait abandons that stall or wait.

## Configuration
- PERF_CNT_EN defined:
  - stall_cnt increments on each LOAD_USE or MEM_WAIT cycle.
  - flush_cnt increments on each BRANCH cycle.
  - Both counters saturate at all-ones.
- PERF_CNT_EN undefined: the counters and both ports are absent.

## Structure
- Shared package:
  - opcode constants OP_RFMT, OP_LW, OP_SW, OP_BEQ
  - an op-class enum (CLS_NOP, CLS_R, CLS_LW, CLS_SW, CLS_BEQ)
  - the stage-tracking record type {valid, cls, dst}
- One sub-module, op_classify: opcode → class, reads_rs, reads_rt, dst select. It is instantiated once, for ID.

## Test plan
- Reset, then R(rd=3) followed by an independent R → all enables 1, no flushes, no stall.
- LW rt=5, then R rs=5 → exactly one cycle with pc_en=0, ifid_en=0, idex_flush=1; RUN on the next cycle.
- LW rt=0, then R rs=0 → no stall.
- BEQ with ex_zero=1 and a dependent R in ID → pc_sel_branch=1 and both flushes for 1 cycle; no load-use stall.
- SW in MEM with mem_ready held low for 3 cycles, plus a taken BEQ in EX → 3 frozen cycles, then the branch flush on the 4th cycle. With PERF_CNT_EN: stall_cnt=3, flush_cnt=1.
- Opcode 6'b111111 with id_valid=1 → illegal_op=1 and no hazard; asserting rst during a load-use stall → enables return to RUN immediately.
